mult_div_unit: RTL

//  Iterative 32-bit multiply/divide unit for the multicycle datapath; consumes start/op from the control unit.

---
 rtl/mult_div_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply (radix-2 Booth) / divide (restoring) unit, one bit per cycle, HI/LO results.
// Optional MULTDIV_UNSIGNED_EN enables multu/divu via op[1]; otherwise every operation is signed.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Two guard bits keep Booth partial sums exact even for a zero-extended multiplicand.
  localparam int unsigned ACC_W = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mcand;
  logic [WIDTH-1:0] qreg;
  logic             q_1;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             uns_c;

`ifdef MULTDIV_UNSIGNED_EN
  logic             fix_hi;
  assign uns_c = op[1];
`else
  logic             unused_op;
  assign unused_op = op[1];
  assign uns_c     = 1'b0;
`endif

  // Request decode and operand magnitudes
  logic             accept_c;
  logic             dz_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;

  assign accept_c = start && (state != S_RUN);
  assign dz_c     = op[0] && (b == '0);
  assign a_neg_c  = !uns_c && a[WIDTH-1];
  assign b_neg_c  = !uns_c && b[WIDTH-1];
  assign a_mag_c  = a_neg_c ? (~a + WIDTH'(1)) : a;
  assign b_mag_c  = b_neg_c ? (~b + WIDTH'(1)) : b;

  // One iteration step for whichever operation is in flight
  logic [ACC_W-1:0] booth_sum_c;
  logic [ACC_W-1:0] acc_nx_c;
  logic [WIDTH-1:0] q_nx_c;
  logic             q1_nx_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH+1:0] trial_c;

  always_comb begin
    booth_sum_c = acc;
    acc_nx_c    = acc;
    q_nx_c      = qreg;
    q1_nx_c     = q_1;
    rem_sh_c    = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    trial_c     = {1'b0, rem_sh_c} - {1'b0, mcand[WIDTH:0]};
    if (is_div) begin
      acc_nx_c = trial_c[WIDTH+1] ? ACC_W'(rem_sh_c) : ACC_W'(trial_c[WIDTH:0]);
      q_nx_c   = {qreg[WIDTH-2:0], !trial_c[WIDTH+1]};
    end else begin
      case ({qreg[0], q_1})
        2'b01:   booth_sum_c = acc + mcand;
        2'b10:   booth_sum_c = acc - mcand;
        default: booth_sum_c = acc;
      endcase
      acc_nx_c = {booth_sum_c[ACC_W-1], booth_sum_c[ACC_W-1:1]};
      q_nx_c   = {booth_sum_c[0], qreg[WIDTH-1:1]};
      q1_nx_c  = qreg[0];
    end
  end

  // Final-edge result with sign fix-up folded in
  logic [WIDTH-1:0] hi_res_c;
  logic [WIDTH-1:0] lo_res_c;

  always_comb begin
    hi_res_c = acc_nx_c[WIDTH-1:0];
    lo_res_c = q_nx_c;
    if (is_div) begin
      if (neg_r) hi_res_c = ~acc_nx_c[WIDTH-1:0] + WIDTH'(1);
      if (neg_q) lo_res_c = ~q_nx_c + WIDTH'(1);
    end
`ifdef MULTDIV_UNSIGNED_EN
    // Booth treats the multiplier as signed; an unsigned multiplier with MSB set needs +a<<WIDTH.
    else if (fix_hi) begin
      hi_res_c = acc_nx_c[WIDTH-1:0] + mcand[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = dz_c ? S_DONE : S_RUN;
      S_RUN:   if (count == CNT_W'(1)) state_nx = S_DONE;
      S_DONE:  if (start) state_nx = dz_c ? S_DONE : S_RUN;
               else       state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs, operand latch and iteration datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      qreg     <= '0;
      q_1      <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      busy <= (state_nx == S_RUN);
      done <= (state_nx == S_DONE);
      if (accept_c) begin
        div_zero <= dz_c;
        is_div   <= op[0];
        acc      <= '0;
        q_1      <= 1'b0;
        count    <= dz_c ? CNT_W'(0) : CNT_W'(WIDTH);
        if (op[0]) begin
          mcand <= {2'b00, b_mag_c};
          qreg  <= a_mag_c;
          neg_q <= a_neg_c ^ b_neg_c;
          neg_r <= a_neg_c;
        end else begin
          mcand <= {{2{a_neg_c}}, a};
          qreg  <= b;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end
      end else if (state == S_RUN) begin
        acc   <= acc_nx_c;
        qreg  <= q_nx_c;
        q_1   <= q1_nx_c;
        count <= count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          hi <= hi_res_c;
          lo <= lo_res_c;
        end
      end
    end
  end

`ifdef MULTDIV_UNSIGNED_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        fix_hi <= 1'b0;
    else if (accept_c) fix_hi <= !op[0] && op[1] && b[WIDTH-1];
  end
`endif

endmodule
